// File: rtl/seg_scan_reader.sv
// Seven-segment bus read-back monitor: inverse-decodes the multiplexed display
// bus into a hex frame, flags illegal glyphs, and watches for a stalled scan.
module seg_scan_reader #(
   parameter int DIGITS         = 4,
   parameter int STABLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_hex,
   input  logic [DIGITS-1:0]     seg_sel,
   output logic [4*DIGITS-1:0]   value,
   output logic                  value_valid,
   output logic [DIGITS-1:0]     digit_err,
   output logic                  frame_err,
   output logic                  scan_lost
);

   // state | meaning
   // SEEK  | select is blank or has several digits lit; nothing to capture
   // COUNT | one digit lit; counting consecutive identical samples
   // HOLD  | digit captured for this dwell; wait for the pair to change
   typedef enum logic [1:0] {SEEK, COUNT, HOLD} state_t;

   localparam int IW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [6:0] BLANK_HEX = 7'b0111111;

   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b1000000: return 5'h00;
         7'b1111001: return 5'h01;
         7'b0100100: return 5'h02;
         7'b0110000: return 5'h03;
         7'b0011001: return 5'h04;
         7'b0010010: return 5'h05;
         7'b0000010: return 5'h06;
         7'b1111000: return 5'h07;
         7'b0000000: return 5'h08;
         7'b0010000: return 5'h09;
         7'b0001000: return 5'h0A;
         7'b0000011: return 5'h0B;
         7'b0100111: return 5'h0C;
         7'b0100001: return 5'h0D;
         7'b0000110: return 5'h0E;
         7'b0001110: return 5'h0F;
         default:    return 5'h10;
      endcase
   endfunction

   state_t                   state_q, state_d;
   logic [DIGITS-1:0]        sel_q, sel_d;
   logic [6:0]               hex_q, hex_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [IW-1:0]            idle_q, idle_d;
   logic [DIGITS-1:0]        captured_q, captured_d;
   logic [DIGITS-1:0][3:0]   slot_nib_q, slot_nib_d;
   logic [DIGITS-1:0]        slot_err_q, slot_err_d;
   logic [4*DIGITS-1:0]      value_q, value_d;
   logic                     valid_q, valid_d;
   logic [DIGITS-1:0]        digit_err_q, digit_err_d;
   logic                     frame_err_q, frame_err_d;
   logic                     lost_q, lost_d;

   logic                     same, new_onehot, capture;
   logic [IDXW-1:0]          idx;
   logic [4:0]               dec;

   always_comb begin
      sel_d      = seg_sel;
      hex_d      = seg_hex;
      // Samples are counted as they enter the input register, so the held
      // pair is compared against the one arriving on this edge.
      same       = (seg_sel == sel_q) && (seg_hex == hex_q);
      new_onehot = $onehot(~seg_sel);
      dec        = decode(hex_q);
      idx        = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!sel_q[i]) idx = IDXW'(i);
      end

      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         SEEK: begin
            cnt_d = '0;
            if (new_onehot) state_d = COUNT;
         end
         COUNT: begin
            if (!same) begin
               cnt_d   = '0;
               state_d = new_onehot ? COUNT : SEEK;
            end else if (cnt_q == 8'(STABLE_CYCLES - 2)) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            cnt_d = '0;
            if (!same) state_d = new_onehot ? COUNT : SEEK;
         end
         default: begin
            cnt_d   = '0;
            state_d = SEEK;
         end
      endcase

      captured_d  = captured_q;
      slot_nib_d  = slot_nib_q;
      slot_err_d  = slot_err_q;
      value_d     = value_q;
      digit_err_d = digit_err_q;
      frame_err_d = frame_err_q;
      valid_d     = 1'b0;
      idle_d      = idle_q;
      lost_d      = lost_q;

      if (&captured_q) begin
         value_d     = slot_nib_q;
         digit_err_d = slot_err_q;
         frame_err_d = |slot_err_q;
         valid_d     = 1'b1;
         captured_d  = '0;
      end

      // A capture on the timeout edge wins; the partial frame survives.
      if (capture) begin
         captured_d[idx] = 1'b1;
         slot_nib_d[idx] = dec[3:0];
         slot_err_d[idx] = dec[4];
         idle_d          = '0;
         lost_d          = 1'b0;
      end else if (idle_q >= IW'(TIMEOUT_CYCLES - 1)) begin
         idle_d     = IW'(TIMEOUT_CYCLES);
         lost_d     = 1'b1;
         captured_d = '0;
      end else begin
         idle_d = idle_q + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SEEK;
         sel_q       <= '1;
         hex_q       <= BLANK_HEX;
         cnt_q       <= '0;
         idle_q      <= '0;
         captured_q  <= '0;
         slot_nib_q  <= '0;
         slot_err_q  <= '0;
         value_q     <= '0;
         valid_q     <= 1'b0;
         digit_err_q <= '0;
         frame_err_q <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         hex_q       <= hex_d;
         cnt_q       <= cnt_d;
         idle_q      <= idle_d;
         captured_q  <= captured_d;
         slot_nib_q  <= slot_nib_d;
         slot_err_q  <= slot_err_d;
         value_q     <= value_d;
         valid_q     <= valid_d;
         digit_err_q <= digit_err_d;
         frame_err_q <= frame_err_d;
         lost_q      <= lost_d;
      end
   end

   assign value       = value_q;
   assign value_valid = valid_q;
   assign digit_err   = digit_err_q;
   assign frame_err   = frame_err_q;
   assign scan_lost   = lost_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboard bench for seg_scan_reader: each driven scan pushes its expected
// frame; the monitor pops and compares on every value_valid pulse.
module tb_seg_scan_reader;

   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_hex;
   logic [3:0]  seg_sel;
   logic [15:0] value;
   logic        value_valid;
   logic [3:0]  digit_err;
   logic        frame_err;
   logic        scan_lost;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses   = 0;
   int mark     = 0;
   logic [19:0] sb [$];

   seg_scan_reader #(.DIGITS(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(100)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_hex     (seg_hex),
      .seg_sel     (seg_sel),
      .value       (value),
      .value_valid (value_valid),
      .digit_err   (digit_err),
      .frame_err   (frame_err),
      .scan_lost   (scan_lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive_raw(input logic [3:0] sel, input logic [6:0] hex, input int n);
      repeat (n) begin
         @(negedge clk);
         seg_sel = sel;
         seg_hex = hex;
      end
   endtask

   task automatic drive_digit(input int d, input logic [6:0] pat, input int n);
      logic [3:0] one;
      one = 4'b0001 << d;
      drive_raw(~one, pat, n);
   endtask

   // order holds four 2-bit digit indices, first-driven in bits [1:0]
   task automatic scan_frame(input logic [15:0] v, input logic [3:0] bad, input logic [7:0] order);
      logic [15:0] ev;
      int d;
      ev = v;
      for (int k = 0; k < 4; k++) begin
         d = int'(order[2*k +: 2]);
         if (bad[d]) ev[4*d +: 4] = 4'h0;
      end
      sb.push_back({bad, ev});
      for (int k = 0; k < 4; k++) begin
         d = int'(order[2*k +: 2]);
         drive_digit(d, bad[d] ? DASH : GLYPH[v[4*d +: 4]], 20);
         drive_raw(4'hF, DASH, 2);
      end
   endtask

   task automatic expect_done(input string tag);
      repeat (4) @(negedge clk);
      check({tag, "_sb_empty"}, sb.size(), 0);
      check({tag, "_pulses"}, pulses - mark, 1);
      mark = pulses;
   endtask

   initial begin : monitor
      logic [19:0] e;
      forever begin
         @(negedge clk);
         if (value_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
               check("unexpected_frame", value, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("value", value, e[15:0]);
               check("digit_err", digit_err, e[19:16]);
               check("frame_err", frame_err, |e[19:16]);
            end
         end
      end
   end

   initial begin : timeout
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin : stim
      rst     = 1'b1;
      seg_sel = 4'hF;
      seg_hex = DASH;
      repeat (3) @(negedge clk);
      check("rst_value", value, 0);
      check("rst_valid", value_valid, 0);
      check("rst_digit_err", digit_err, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_scan_lost", scan_lost, 0);
      rst = 1'b0;
      drive_raw(4'hF, DASH, 3);

      // clean scan 3,A,0,7 on digits 0..3
      scan_frame(16'h70A3, 4'b0000, 8'hE4);
      expect_done("clean");

      // dash on digit 2
      scan_frame(16'h70A3, 4'b0100, 8'hE4);
      expect_done("illegal");

      // short dwell then glitched dwell on digit 1
      sb.push_back({4'b0000, 16'hCE59});
      drive_digit(0, GLYPH[9], 20);  drive_raw(4'hF, DASH, 2);
      drive_digit(2, GLYPH[14], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(3, GLYPH[12], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(1, GLYPH[5], 7);   drive_raw(4'hF, DASH, 2);
      repeat (4) @(negedge clk);
      check("short_no_frame", pulses - mark, 0);
      check("short_sb_pending", sb.size(), 1);
      drive_digit(1, GLYPH[5], 5);
      drive_digit(1, GLYPH[5] ^ 7'b0000001, 1);
      drive_digit(1, GLYPH[5], 14);
      drive_raw(4'hF, DASH, 2);
      expect_done("glitch");

      // multiple selects, then reordered scan 3,1,0,2
      drive_raw(4'b1100, GLYPH[1], 30);
      drive_raw(4'hF, DASH, 2);
      check("multisel_no_frame", pulses - mark, 0);
      scan_frame(16'h1F4D, 4'b0000, 8'h87);
      expect_done("reorder");

      // watchdog discards a partial frame
      sb.push_back({4'b0000, 16'h4321});
      drive_digit(0, GLYPH[5], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(1, GLYPH[6], 20);
      drive_raw(4'hF, DASH, 100);
      check("lost_set", scan_lost, 1);
      drive_digit(2, GLYPH[3], 10);
      check("lost_clear", scan_lost, 0);
      drive_digit(2, GLYPH[3], 10); drive_raw(4'hF, DASH, 2);
      drive_digit(3, GLYPH[4], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(0, GLYPH[1], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(1, GLYPH[2], 20); drive_raw(4'hF, DASH, 2);
      expect_done("watchdog");

      // async reset after three captures
      drive_digit(0, GLYPH[9], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(1, GLYPH[8], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(2, GLYPH[7], 20); drive_raw(4'hF, DASH, 2);
      drive_digit(3, GLYPH[6], 5);
      #2 rst = 1'b1;
      #1;
      check("arst_value", value, 0);
      check("arst_valid", value_valid, 0);
      check("arst_digit_err", digit_err, 0);
      check("arst_frame_err", frame_err, 0);
      check("arst_scan_lost", scan_lost, 0);
      drive_raw(4'hF, DASH, 2);
      rst = 1'b0;
      drive_raw(4'hF, DASH, 2);
      check("arst_no_frame", pulses - mark, 0);
      scan_frame(16'h1234, 4'b0000, 8'hE4);
      expect_done("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
